// File: rtl/alu_share_ctrl_if.sv
// Requester and response channels of the shared-ALU controller.
// The controller side uses the slave modport; requesters/consumers use master.
interface alu_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_SHARE_OPCHK_EN: illegal opcodes are suppressed and flagged via rsp_err.
module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_ctrl_if.slave     bus,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [3:0]          alu_control,
  input  logic [W-1:0]        alu_result,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]     op_code_q, op_code_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           op_ill_q, op_ill_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  int             sum;
  logic [W-1:0]   sel_a, sel_b;
  logic [3:0]     sel_op;
  logic           sel_ill;
  logic [NREQ-1:0] req_ready_c;

  // First pending requester after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    sum       = 0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = int'(rr_ptr_q) + i;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = IDW'(sum);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign sel_a  = bus.req_a[int'(win_id)*W +: W];
  assign sel_b  = bus.req_b[int'(win_id)*W +: W];
  assign sel_op = bus.req_op[int'(win_id)*4 +: 4];

`ifdef ALU_SHARE_OPCHK_EN
  assign sel_ill = !(sel_op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100});
`else
  assign sel_ill = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    op_id_d     = op_id_q;
    op_ill_d    = op_ill_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready_c[win_id] = 1'b1;
          op_a_d    = sel_a;
          op_b_d    = sel_b;
          op_code_d = sel_op;
          op_id_d   = win_id;
          op_ill_d  = sel_ill;
          rr_ptr_d  = win_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = op_ill_q ? '0 : alu_result;
        rsp_id_d   = op_id_q;
        rsp_err_d  = op_ill_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU sees a NOP except during a legal operation's EXEC cycle.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 4'b0000;
    if (state_q == EXEC && !op_ill_q) begin
      alu_a       = op_a_q;
      alu_b       = op_b_q;
      alu_control = op_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDW'(NREQ - 1);
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_code_q  <= 4'b0000;
      op_id_q    <= '0;
      op_ill_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_code_q  <= op_code_d;
      op_id_q    <= op_id_d;
      op_ill_q   <= op_ill_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready = rst ? '0 : req_ready_c;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl with a behavioural ALU stand-in.
// Expected values for illegal opcodes follow ALU_SHARE_OPCHK_EN.
`timescale 1ns/1ps
module tb_alu_share_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_control;
  logic         busy;
  int           vecCount = 0;
  int           errCount = 0;

  alu_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Unknown opcodes return a^b so an unfiltered pass-through is observable.
  always_comb begin
    case (alu_control)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a & alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setReq(input int id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[id]       = 1'b1;
    bus.req_op[id*4 +: 4]   = op;
    bus.req_a[id*W +: W]    = a;
    bus.req_b[id*W +: W]    = b;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      nextCycle();
      n++;
    end
    #1;
    if (busy) checkOutput({tag, "_idle_timeout"}, 1, 0);
  endtask

  // One isolated operation: grant now, EXEC next cycle, response two cycles after the grant.
  task automatic applyStimulus(input string tag, input int id, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [3:0] expCtrl, input logic [W-1:0] expAluA,
                               input logic [W-1:0] expData, input logic expErr);
    setReq(id, op, a, b);
    #1;
    checkOutput({tag, "_grant"}, bus.req_ready, 32'(1 << id));
    nextCycle();
    bus.req_valid[id] = 1'b0;
    #1;
    checkOutput({tag, "_exec_ctrl"}, alu_control, expCtrl);
    checkOutput({tag, "_exec_a"}, alu_a, expAluA);
    checkOutput({tag, "_exec_rspv"}, bus.rsp_valid, 0);
    nextCycle();
    #1;
    checkOutput({tag, "_rspv"}, bus.rsp_valid, 1);
    checkOutput({tag, "_data"}, bus.rsp_data, expData);
    checkOutput({tag, "_id"}, bus.rsp_id, id);
    checkOutput({tag, "_err"}, bus.rsp_err, expErr);
    nextCycle();
    #1;
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expOrder[5];
    int g, r, lastCyc;
    expOrder = '{0, 1, 2, 3, 0};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rspv", bus.rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", bus.req_ready, 0);
    checkOutput("rst_ctrl", alu_control, 0);
    checkOutput("rst_data", bus.rsp_data, 0);
    rst = 1'b0;

    // Round-robin with all requesters continuously valid.
    for (int i = 0; i < NREQ; i++) setReq(i, 4'b0001, W'(100 + i), W'(1));
    g = 0; r = 0; lastCyc = 0;
    for (int c = 0; c < 40 && g < 5; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        checkOutput("rr_grant", bus.req_ready, 32'(1 << expOrder[g]));
        if (g > 0) checkOutput("rr_gap", c - lastCyc, 3);
        lastCyc = c;
        g++;
      end
      if (bus.rsp_valid && r < 5) begin
        checkOutput("rr_rsp_id", bus.rsp_id, expOrder[r]);
        checkOutput("rr_rsp_data", bus.rsp_data, 101 + expOrder[r]);
        r++;
      end
      if (g < 5) nextCycle();
    end
    checkOutput("rr_grants_seen", g, 5);
    nextCycle();
    bus.req_valid = '0;
    waitIdle("rr");

    // Backpressure: response held while rsp_ready is low, req 3 waits.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    setReq(1, 4'b0001, 16'd7, 16'd8);
    setReq(3, 4'b0011, 16'hF0F0, 16'h0FF0);
    #1;
    checkOutput("bp_grant1", bus.req_ready, 32'b0010);
    nextCycle();
    bus.req_valid[1] = 1'b0;
    #1;
    checkOutput("bp_exec_ready", bus.req_ready, 0);
    nextCycle();
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_rspv", bus.rsp_valid, 1);
      checkOutput("bp_data", bus.rsp_data, 15);
      checkOutput("bp_ready", bus.req_ready, 0);
      checkOutput("bp_busy", busy, 1);
      nextCycle();
      #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp_hs_rspv", bus.rsp_valid, 1);
    checkOutput("bp_hs_id", bus.rsp_id, 1);
    nextCycle();
    #1;
    checkOutput("bp_grant3", bus.req_ready, 32'b1000);
    nextCycle();
    bus.req_valid[3] = 1'b0;
    nextCycle();
    #1;
    checkOutput("bp_data3", bus.rsp_data, 16'h00F0);
    checkOutput("bp_id3", bus.rsp_id, 3);
    nextCycle();
    waitIdle("bp");
    @(negedge clk);

    applyStimulus("wrap_sub", 2, 4'b0010, 16'd5, 16'd10, 4'b0010, 16'd5, 16'hFFFB, 1'b0);
`ifdef ALU_SHARE_OPCHK_EN
    applyStimulus("illegal", 1, 4'b0111, 16'd3, 16'd5, 4'b0000, 16'd0, 16'd0, 1'b1);
`else
    applyStimulus("illegal", 1, 4'b0111, 16'd3, 16'd5, 4'b0111, 16'd3, 16'd6, 1'b0);
`endif
    applyStimulus("add", 0, 4'b0001, 16'd10, 16'd5, 4'b0001, 16'd10, 16'd15, 1'b0);
    applyStimulus("sub", 0, 4'b0010, 16'd10, 16'd5, 4'b0010, 16'd10, 16'd5, 1'b0);
    applyStimulus("and", 0, 4'b0011, 16'b1010, 16'b1100, 4'b0011, 16'b1010, 16'd8, 1'b0);
    applyStimulus("or", 0, 4'b0100, 16'b1010, 16'b1100, 4'b0100, 16'b1010, 16'd14, 1'b0);

    // Reset during EXEC: op discarded, rr_ptr back to NREQ-1 so req 0 beats req 2.
    setReq(0, 4'b0001, 16'd1, 16'd2);
    setReq(1, 4'b0010, 16'd9, 16'd4);
    setReq(2, 4'b0100, 16'd1, 16'd2);
    #1;
    checkOutput("mr_grant1", bus.req_ready, 32'b0010);
    nextCycle();
    bus.req_valid[1] = 1'b0;
    #1;
    checkOutput("mr_exec_ctrl", alu_control, 4'b0010);
    rst = 1'b1;
    nextCycle();
    #1;
    checkOutput("mr_rspv", bus.rsp_valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_ready", bus.req_ready, 0);
    checkOutput("mr_ctrl", alu_control, 0);
    checkOutput("mr_alu_a", alu_a, 0);
    checkOutput("mr_alu_b", alu_b, 0);
    checkOutput("mr_data", bus.rsp_data, 0);
    checkOutput("mr_id", bus.rsp_id, 0);
    checkOutput("mr_err", bus.rsp_err, 0);
    rst = 1'b0;
    #1;
    checkOutput("mr_grant0", bus.req_ready, 32'b0001);
    nextCycle();
    bus.req_valid = '0;
    #1;
    checkOutput("mr_exec_ctrl0", alu_control, 4'b0001);
    nextCycle();
    #1;
    checkOutput("mr_rsp_data", bus.rsp_data, 3);
    checkOutput("mr_rsp_id", bus.rsp_id, 0);
    nextCycle();
    waitIdle("mr");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
